// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory-access pipeline stage.
package mem_access_pkg;

    localparam int BE_WIDTH = 4;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic {
        MA_IDLE   = 1'b0,
        MA_ACCESS = 1'b1
    } ma_state_t;

    // The reserved encoding 2'b11 behaves as a word access.
    function automatic mem_size_t decode_size(input logic [1:0] size);
        case (size)
            2'b00:   return MEM_BYTE;
            2'b01:   return MEM_HALF;
            default: return MEM_WORD;
        endcase
    endfunction

    function automatic logic addr_misaligned(input mem_size_t size, input logic [1:0] addr);
        case (size)
            MEM_HALF: return addr[0];
            MEM_WORD: return addr != 2'b00;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/half/word from a bus read word and extends it.
module mem_load_align
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            addr,
    input  mem_size_t             size,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        case (size)
            MEM_BYTE: data = {{(DATA_WIDTH-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
            MEM_HALF: data = {{(DATA_WIDTH-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
            default:  data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: single-outstanding req/ack data-memory port, upstream
// stall while an access is pending, registered result towards write-back.
module mem_access_stage
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_IE_valid,
    input  logic [DATA_WIDTH-1:0]     i_IE_result,
    input  logic [DATA_WIDTH-1:0]     i_IE_data_write,
    input  logic [REG_ADDR_WIDTH-1:0] i_IE_rd_addr,
    input  logic                      i_ctrl_mem_read,
    input  logic                      i_ctrl_mem_write,
    input  logic [1:0]                i_ctrl_mem_size,
    input  logic                      i_ctrl_mem_unsigned,
    input  logic                      i_ctrl_reg_write,
    output logic                      o_MA_stall,
    output logic                      o_dmem_req,
    output logic                      o_dmem_we,
    output logic [ADDR_WIDTH-1:0]     o_dmem_addr,
    output logic [DATA_WIDTH-1:0]     o_dmem_wdata,
    output logic [BE_WIDTH-1:0]       o_dmem_be,
    input  logic                      i_dmem_ack,
    input  logic [DATA_WIDTH-1:0]     i_dmem_rdata,
    output logic                      o_MA_valid,
    output logic [DATA_WIDTH-1:0]     o_MA_result,
    output logic [REG_ADDR_WIDTH-1:0] o_MA_rd_addr,
    output logic                      o_MA_reg_write,
    output logic                      o_MA_misaligned
);

    ma_state_t                 state, state_next;
    mem_size_t                 size_in, size_q;
    logic                      is_mem, misaligned;
    logic                      accept, start_access, accept_direct, mem_done, out_busy;
    logic [BE_WIDTH-1:0]       be_in, be_q;
    logic [DATA_WIDTH-1:0]     wdata_in, wdata_q, load_data, mem_result;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      we_q, unsigned_q, reg_write_q;

    // A non-memory result accepted on an ack cycle collides with the load/store
    // result for the same edge; it waits here for one cycle, keeping order.
    logic                      pend_valid, pend_reg_write, pend_misaligned;
    logic [DATA_WIDTH-1:0]     pend_result;
    logic [REG_ADDR_WIDTH-1:0] pend_rd;

    always_comb begin
        size_in    = decode_size(i_ctrl_mem_size);
        is_mem     = i_ctrl_mem_read | i_ctrl_mem_write;
        misaligned = is_mem && addr_misaligned(size_in, i_IE_result[1:0]);
        case (size_in)
            MEM_BYTE: begin
                be_in    = BE_WIDTH'(4'b0001) << i_IE_result[1:0];
                wdata_in = {4{i_IE_data_write[7:0]}};
            end
            MEM_HALF: begin
                be_in    = BE_WIDTH'(4'b0011) << {i_IE_result[1], 1'b0};
                wdata_in = {2{i_IE_data_write[15:0]}};
            end
            default: begin
                be_in    = '1;
                wdata_in = i_IE_data_write;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= MA_IDLE;
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        else            state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_next = state;
        accept     = 1'b0;
        mem_done   = 1'b0;
        o_MA_stall = 1'b0;
        o_dmem_req = 1'b0;
        case (state)
            MA_IDLE: accept = i_IE_valid;
            MA_ACCESS: begin
                o_dmem_req = 1'b1;
                mem_done   = i_dmem_ack;
                o_MA_stall = ~i_dmem_ack;
                accept     = i_IE_valid & i_dmem_ack;
                if (i_dmem_ack) state_next = MA_IDLE;
            end
            default: state_next = MA_IDLE;
        endcase
        start_access  = accept & is_mem & ~misaligned;
        accept_direct = accept & ~start_access;
        if (start_access) state_next = MA_ACCESS;
    end

    // NOTE: the access registers are reset too, so the bus outputs read 0 in reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            size_q      <= MEM_BYTE;
            unsigned_q  <= 1'b0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
        end else if (start_access) begin
            addr_q      <= i_IE_result[ADDR_WIDTH-1:0];
            wdata_q     <= wdata_in;
            be_q        <= be_in;
            we_q        <= i_ctrl_mem_write;
            size_q      <= size_in;
            unsigned_q  <= i_ctrl_mem_unsigned;
            rd_q        <= i_IE_rd_addr;
            reg_write_q <= i_ctrl_reg_write;
        end
    end

    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign o_dmem_wdata = wdata_q;
    assign o_dmem_be    = be_q;

    mem_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
        .rdata       (i_dmem_rdata),
        .addr        (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .data        (load_data)
    );

    assign mem_result = we_q ? DATA_WIDTH'(addr_q) : load_data;
    assign out_busy   = mem_done | pend_valid;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_MA_valid      <= 1'b0;
            o_MA_result     <= '0;
            o_MA_rd_addr    <= '0;
            o_MA_reg_write  <= 1'b0;
            o_MA_misaligned <= 1'b0;
            pend_valid      <= 1'b0;
            pend_result     <= '0;
            pend_rd         <= '0;
            pend_reg_write  <= 1'b0;
            pend_misaligned <= 1'b0;
        end else begin
            o_MA_valid <= 1'b0;
            if (mem_done) begin
                o_MA_valid      <= 1'b1;
                o_MA_result     <= mem_result;
                o_MA_rd_addr    <= rd_q;
                o_MA_reg_write  <= reg_write_q & ~we_q;
                o_MA_misaligned <= 1'b0;
            end else if (pend_valid) begin
                o_MA_valid      <= 1'b1;
                o_MA_result     <= pend_result;
                o_MA_rd_addr    <= pend_rd;
                o_MA_reg_write  <= pend_reg_write;
                o_MA_misaligned <= pend_misaligned;
            end else if (accept_direct) begin
                o_MA_valid      <= 1'b1;
                o_MA_result     <= i_IE_result;
                o_MA_rd_addr    <= i_IE_rd_addr;
                o_MA_reg_write  <= i_ctrl_reg_write & ~misaligned;
                o_MA_misaligned <= misaligned;
            end

            if (accept_direct && out_busy) begin
                pend_valid      <= 1'b1;
                pend_result     <= i_IE_result;
                pend_rd         <= i_IE_rd_addr;
                pend_reg_write  <= i_ctrl_reg_write & ~misaligned;
                pend_misaligned <= misaligned;
            end else if (!mem_done) begin
                pend_valid      <= 1'b0;
            end
        end
    end

endmodule
